branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor_if.sv | 31 +++
 rtl/branch_predictor.sv | 123 ++++++++++++
 tb/tb_branch_predictor.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Fetch/execute port bundle for branch_predictor.
// master = pipeline side; slave = predictor side.
interface branch_predictor_if #(
    parameter int GHR_BITS = 6
);
    logic [31:0]         fetch_pc;
    logic [1:0]          btb_flag;
    logic [31:0]         pred_target;
    logic [GHR_BITS-1:0] pred_ghr;
    logic                update;
    logic                update_btb;
    logic [31:0]         upd_pc;
    logic                upd_taken;
    logic [31:0]         upd_target;
    logic [GHR_BITS-1:0] upd_ghr;
    logic                mispredict;
    logic [31:0]         stat_branches;
    logic [31:0]         stat_mispredicts;

    modport master (
        output fetch_pc, update, update_btb, upd_pc, upd_taken,
               upd_target, upd_ghr, mispredict,
        input  btb_flag, pred_target, pred_ghr, stat_branches, stat_mispredicts
    );

    modport slave (
        input  fetch_pc, update, update_btb, upd_pc, upd_taken,
               upd_target, upd_ghr, mispredict,
        output btb_flag, pred_target, pred_ghr, stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/branch_predictor.sv
// 2-bit counter PHT plus direct-mapped BTB with zero-latency lookup.
// Define BP_GSHARE_EN for gshare PHT indexing; the default build is bimodal.
module branch_predictor #(
    parameter int IDX_BITS = 6,
    parameter int TAG_BITS = 8,
    parameter int GHR_BITS = 6
) (
    input  logic              clk,
    input  logic              rst,
    branch_predictor_if.slave bus
);
    localparam int ENTRIES = 1 << IDX_BITS;
    typedef logic [IDX_BITS-1:0] idx_t;

    logic [1:0]          pht_q        [ENTRIES];
    logic [ENTRIES-1:0]  btb_valid_q;
    logic [TAG_BITS-1:0] btb_tag_q    [ENTRIES];
    logic [31:0]         btb_target_q [ENTRIES];
    logic [31:0]         stat_branches_q, stat_branches_d;
    logic [31:0]         stat_mispredicts_q, stat_mispredicts_d;

    idx_t                fetch_bidx, upd_bidx, fidx, uidx;
    logic [TAG_BITS-1:0] fetch_tag, upd_tag;
    logic                fetch_hit;
    logic [1:0]          pht_upd_d;
    logic                btb_alloc;
    logic                unused_ok;

    assign fetch_bidx = bus.fetch_pc[IDX_BITS+1:2];
    assign upd_bidx   = bus.upd_pc[IDX_BITS+1:2];
    assign fetch_tag  = bus.fetch_pc[IDX_BITS+2 +: TAG_BITS];
    assign upd_tag    = bus.upd_pc[IDX_BITS+2 +: TAG_BITS];
    assign unused_ok  = ^{bus.fetch_pc, bus.upd_pc, bus.upd_ghr};

`ifdef BP_GSHARE_EN
    logic [GHR_BITS-1:0] ghr_q;

    // History only advances on resolved branches, so it is never rolled back.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q <= '0;
        end else if (bus.update) begin
            ghr_q <= GHR_BITS'({ghr_q, bus.upd_taken});
        end
    end

    assign fidx         = fetch_bidx ^ idx_t'(ghr_q);
    assign uidx         = upd_bidx ^ idx_t'(bus.upd_ghr);
    assign bus.pred_ghr = ghr_q;
`else
    assign fidx         = fetch_bidx;
    assign uidx         = upd_bidx;
    assign bus.pred_ghr = '0;
`endif

    // Lookup reads pre-edge state only; a same-cycle write shows up next cycle.
    assign fetch_hit       = btb_valid_q[fetch_bidx] && (btb_tag_q[fetch_bidx] == fetch_tag);
    assign bus.btb_flag    = {fetch_hit, fetch_hit & pht_q[fidx][1]};
    assign bus.pred_target = fetch_hit ? btb_target_q[fetch_bidx] : 32'd0;

    always_comb begin
        pht_upd_d = pht_q[uidx];
        if (bus.upd_taken) begin
            if (pht_q[uidx] != 2'b11) begin
                pht_upd_d = pht_q[uidx] + 2'd1;
            end
        end else if (pht_q[uidx] != 2'b00) begin
            pht_upd_d = pht_q[uidx] - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pht_q <= '{default: 2'b01};
        end else if (bus.update) begin
            pht_q[uidx] <= pht_upd_d;
        end
    end

    assign btb_alloc = bus.update_btb & bus.upd_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            btb_valid_q <= '0;
        end else if (btb_alloc) begin
            btb_valid_q[upd_bidx] <= 1'b1;
        end
    end

    // Tag/target payload is not reset: the cleared valid bit masks it.
    always_ff @(posedge clk) begin
        if (!rst && btb_alloc) begin
            btb_tag_q[upd_bidx]    <= upd_tag;
            btb_target_q[upd_bidx] <= bus.upd_target;
        end
    end

    always_comb begin
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (bus.update) begin
            if (stat_branches_q != 32'hFFFF_FFFF) begin
                stat_branches_d = stat_branches_q + 32'd1;
            end
            if (bus.mispredict && (stat_mispredicts_q != 32'hFFFF_FFFF)) begin
                stat_mispredicts_d = stat_mispredicts_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign bus.stat_branches    = stat_branches_q;
    assign bus.stat_mispredicts = stat_mispredicts_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed corner cases, then random
// traffic compared every cycle against an array-based behavioural model.
module tb_branch_predictor;
    localparam int IDX  = 6;
    localparam int TAGB = 8;
    localparam int GHRB = 6;
    localparam int N    = 1 << IDX;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    branch_predictor_if #(.GHR_BITS(GHRB)) bus ();

    branch_predictor #(.IDX_BITS(IDX), .TAG_BITS(TAGB), .GHR_BITS(GHRB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model
    int          m_pht    [N];
    bit          m_valid  [N];
    int unsigned m_tag    [N];
    int unsigned m_target [N];
    int unsigned m_ghr;
    longint      m_br, m_mp;

    function automatic int pidx(input int unsigned pc, input int unsigned h);
`ifdef BP_GSHARE_EN
        return int'(((pc >> 2) ^ h) % N);
`else
        return int'((pc >> 2) % N);
`endif
    endfunction

    function automatic int bidx(input int unsigned pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic int unsigned tagof(input int unsigned pc);
        return (pc >> (IDX + 2)) % (1 << TAGB);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_update();
        int i;
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                m_pht[k]   = 1;
                m_valid[k] = 1'b0;
            end
            m_ghr = 0;
            m_br  = 0;
            m_mp  = 0;
        end else begin
            if (bus.update) begin
                i = pidx(bus.upd_pc, bus.upd_ghr);
                if (bus.upd_taken) m_pht[i] = (m_pht[i] < 3) ? m_pht[i] + 1 : 3;
                else               m_pht[i] = (m_pht[i] > 0) ? m_pht[i] - 1 : 0;
                m_ghr = ((m_ghr << 1) | bus.upd_taken) % (1 << GHRB);
                if (m_br < 64'hFFFF_FFFF) m_br++;
                if (bus.mispredict && m_mp < 64'hFFFF_FFFF) m_mp++;
            end
            if (bus.update_btb && bus.upd_taken) begin
                i = bidx(bus.upd_pc);
                m_valid[i]  = 1'b1;
                m_tag[i]    = tagof(bus.upd_pc);
                m_target[i] = bus.upd_target;
            end
        end
    endtask

    // One clock: compare pre-edge outputs with the model, then clock both.
    task automatic cycle(input bit cmp, input string tag);
        int          b;
        bit          hit;
        logic [1:0]  e_flag;
        int unsigned e_tgt, e_ghr;
        #1;
        if (cmp) begin
            b      = bidx(bus.fetch_pc);
            hit    = m_valid[b] && (m_tag[b] == tagof(bus.fetch_pc));
            e_flag = {hit, hit && (m_pht[pidx(bus.fetch_pc, m_ghr)] >= 2)};
            e_tgt  = hit ? m_target[b] : 0;
`ifdef BP_GSHARE_EN
            e_ghr  = m_ghr;
`else
            e_ghr  = 0;
`endif
            check({tag, "_flag"}, 64'(bus.btb_flag), 64'(e_flag));
            check({tag, "_tgt"},  64'(bus.pred_target), 64'(e_tgt));
            check({tag, "_ghr"},  64'(bus.pred_ghr), 64'(e_ghr));
            check({tag, "_nbr"},  64'(bus.stat_branches), 64'(m_br));
            check({tag, "_nmp"},  64'(bus.stat_mispredicts), 64'(m_mp));
        end
        $display("txn %s rst=%b pc=%h flag=%b tgt=%h upd=%b btb=%b upc=%h t=%b",
                 tag, rst, bus.fetch_pc, bus.btb_flag, bus.pred_target,
                 bus.update, bus.update_btb, bus.upd_pc, bus.upd_taken);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input int unsigned fpc, input bit upd, input bit ubtb,
                         input int unsigned upc, input bit taken,
                         input int unsigned tgt, input bit mp);
        bus.fetch_pc   = fpc;
        bus.update     = upd;
        bus.update_btb = ubtb;
        bus.upd_pc     = upc;
        bus.upd_taken  = taken;
        bus.upd_target = tgt;
        bus.upd_ghr    = GHRB'(m_ghr);
        bus.mispredict = mp;
    endtask

    task automatic peek(input int unsigned fpc);
        drive(fpc, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
        cycle(1'b0, "rst");
        cycle(1'b0, "rst");
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned mp_base;
        bit          pred;

        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
        do_reset();

        // After reset nothing hits
        peek(32'h60);
        check("rst_flag", 64'(bus.btb_flag), 64'd0);
        check("rst_tgt",  64'(bus.pred_target), 64'd0);
        check("rst_nbr",  64'(bus.stat_branches), 64'd0);

        // Two taken allocations train 0x40 to strongly taken
        repeat (2) begin
            drive(32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0);
            cycle(1'b1, "alloc40");
        end
        peek(32'h40);
        check("alloc40_tgt", 64'(bus.pred_target), 64'h80);
`ifndef BP_GSHARE_EN
        check("alloc40_flag", 64'(bus.btb_flag), 64'b11);
`endif

        // Saturate down, then show it does not wrap
        for (int k = 0; k < 4; k++) begin
            drive(32'h40, 1'b1, 1'b0, 32'h40, 1'b0, 0, 1'b0);
            cycle(1'b1, "dec40");
`ifndef BP_GSHARE_EN
            if (k >= 2) begin
                peek(32'h40);
                check("dec40_flag", 64'(bus.btb_flag), 64'b10);
            end
`endif
        end
        drive(32'h40, 1'b1, 1'b0, 32'h40, 1'b1, 0, 1'b0);
        cycle(1'b1, "inc40");
`ifndef BP_GSHARE_EN
        peek(32'h40);
        check("inc40_flag", 64'(bus.btb_flag), 64'b10);
`endif

        // Aliasing PC with a different tag
        peek(32'h40 + 4 * N);
        check("alias_miss", 64'(bus.btb_flag[1]), 64'd0);
        drive(32'h40 + 4 * N, 1'b0, 1'b1, 32'h40 + 4 * N, 1'b1, 32'h200, 1'b1);
        cycle(1'b1, "alias_alloc");
        peek(32'h40);
        check("evicted_hit", 64'(bus.btb_flag[1]), 64'd0);
        check("evicted_tgt", 64'(bus.pred_target), 64'd0);
        peek(32'h40 + 4 * N);
        check("alias_hit", 64'(bus.btb_flag[1]), 64'd1);
        check("alias_tgt", 64'(bus.pred_target), 64'h200);

        // Not-taken allocation request is ignored
        drive(32'h44, 1'b0, 1'b1, 32'h44, 1'b0, 32'h300, 1'b0);
        cycle(1'b1, "nt_alloc");
        peek(32'h44);
        check("nt_alloc_hit", 64'(bus.btb_flag[1]), 64'd0);

        // Reset wins over a coincident update
        rst = 1'b1;
        drive(32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b1);
        cycle(1'b1, "rst_upd");
        rst = 1'b0;
        peek(32'h40);
        check("rst_upd_nbr", 64'(bus.stat_branches), 64'd0);
        check("rst_upd_hit", 64'(bus.btb_flag), 64'd0);
        drive(32'h40, 1'b0, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0);
        cycle(1'b1, "rst_realloc");
        peek(32'h40);
        check("rst_pht01", 64'(bus.btb_flag), 64'b10);
        check("rst_noupd_nbr", 64'(bus.stat_branches), 64'd0);

        // Alternating pattern on one PC
        do_reset();
        drive(32'h40, 1'b0, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0);
        cycle(1'b1, "alt_alloc");
        mp_base = 0;
        for (int k = 0; k < 20; k++) begin
            peek(32'h40);
            pred = bus.btb_flag[0];
            if (k == 10) mp_base = bus.stat_mispredicts;
            drive(32'h40, 1'b1, 1'b0, 32'h40, (k % 2) == 0, 0, pred != ((k % 2) == 0));
            cycle(1'b1, "alt");
        end
        check("alt_nbr", 64'(bus.stat_branches), 64'd20);
`ifdef BP_GSHARE_EN
        check("alt_late_mp", 64'(bus.stat_mispredicts - mp_base), 64'd0);
`endif

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            int unsigned fpc, upc;
            fpc = ($urandom_range(0, 2) << (IDX + 2)) | ($urandom_range(0, 11) << 2);
            upc = ($urandom_range(0, 2) << (IDX + 2)) | ($urandom_range(0, 11) << 2);
            if ($urandom_range(0, 7) == 0) fpc = $urandom;
            if ($urandom_range(0, 3) == 0) upc = fpc;
            drive(fpc, 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, upc,
                  1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) bus.upd_ghr = GHRB'($urandom);
            rst = ($urandom_range(0, 79) == 0);
            cycle(1'b1, "rnd");
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
